// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: magnitude width derivation, kernel weights and the
// default-width 3x3 window type.
package sobel_pkg;

    localparam int WIN_TAPS        = 9;
    // Kernel weights are powers of two, so they are applied as shifts.
    localparam int K_SIDE_SHIFT    = 0;
    localparam int K_CENTRE_SHIFT  = 1;
    localparam int DEFAULT_PIXEL_W = 8;

    typedef logic [WIN_TAPS-1:0][DEFAULT_PIXEL_W-1:0] sobel_win_t;

    function automatic int sobel_mag_w(input int pixel_w);
        return pixel_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: combinational read of the old word at addr_i,
// write of the new word on the same accepted beat.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter  int DEPTH  = 640,
    parameter  int DATA_W = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/sobel_stream_detector.sv
// Streaming Sobel |Gx|+|Gy| detector with line buffers, run-time threshold,
// frame sync and a stall-on-backpressure 3-stage pipeline.
module sobel_stream_detector
    import sobel_pkg::*;
#(
    parameter  int PIXEL_W    = 8,
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    localparam int MAG_W      = sobel_mag_w(PIXEL_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAG_W-1:0]   cfg_threshold,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_sof,
    input  logic [PIXEL_W-1:0] s_pixel,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sof,
    output logic [MAG_W-1:0]   m_mag,
    output logic               m_edge
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int SUM_W = PIXEL_W + 2;
    localparam int G_W   = PIXEL_W + 3;

    typedef logic [WIN_TAPS-1:0][PIXEL_W-1:0] win_t;

    function automatic logic [SUM_W-1:0] side_sum(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] m,
                                                  input logic [PIXEL_W-1:0] b);
        return (SUM_W'(a) << K_SIDE_SHIFT) + (SUM_W'(m) << K_CENTRE_SHIFT)
             + (SUM_W'(b) << K_SIDE_SHIFT);
    endfunction

    function automatic logic signed [G_W-1:0] grad(input logic [SUM_W-1:0] pos,
                                                   input logic [SUM_W-1:0] neg);
        return $signed({1'b0, pos}) - $signed({1'b0, neg});
    endfunction

    // |G| never exceeds 4*(2^PIXEL_W-1), so negation cannot overflow.
    function automatic logic [MAG_W-1:0] abs_g(input logic signed [G_W-1:0] g);
        return g[G_W-1] ? MAG_W'($unsigned(-g)) : MAG_W'($unsigned(g));
    endfunction

    logic                        rst_q;
    logic [COL_W-1:0]            col_q, col_d, col_eff;
    logic [ROW_W-1:0]            row_q, row_d, row_eff;
    logic [MAG_W-1:0]            thr_q, thr_d;
    logic                        stall, advance, accept, first_px;
    logic [2*PIXEL_W-1:0]        lb_rdata;
    logic [PIXEL_W-1:0]          tap_up1, tap_up2;
    win_t                        win_q, win_d;
    logic                        vld_p0_q, sof_p0_q;
    logic [MAG_W-1:0]            thr_p0_q;
    logic signed [G_W-1:0]       gx_p1_q, gy_p1_q;
    logic                        vld_p1_q, sof_p1_q;
    logic [MAG_W-1:0]            thr_p1_q;
    logic [MAG_W-1:0]            mag_p2_q;
    logic                        edge_p2_q, vld_p2_q, sof_p2_q;

    assign stall   = vld_p2_q && !m_ready;
    assign advance = !stall;
    assign s_ready = !rst_q && !stall;
    assign accept  = s_valid && s_ready;

    always_comb begin
        col_eff  = s_sof ? '0 : col_q;
        row_eff  = s_sof ? '0 : row_q;
        first_px = (col_eff == '0) && (row_eff == '0);
        col_d    = col_q;
        row_d    = row_q;
        thr_d    = thr_q;
        if (accept) begin
            if (col_eff == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_eff == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_eff + ROW_W'(1);
            end else begin
                col_d = col_eff + COL_W'(1);
                row_d = row_eff;
            end
            if (first_px) begin
                thr_d = cfg_threshold;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= 1'b1;
            col_q <= '0;
            row_q <= '0;
            thr_q <= '0;
        end else begin
            rst_q <= 1'b0;
            col_q <= col_d;
            row_q <= row_d;
            thr_q <= thr_d;
        end
    end

    // Each entry holds {pixel of row-1, pixel of row} for its column.
    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (2 * PIXEL_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_eff),
        .wdata_i ({tap_up1, s_pixel}),
        .rdata_o (lb_rdata)
    );

    assign {tap_up2, tap_up1} = lb_rdata;

    always_comb begin
        win_d    = win_q;
        win_d[0] = win_q[1];
        win_d[1] = win_q[2];
        win_d[2] = tap_up2;
        win_d[3] = win_q[4];
        win_d[4] = win_q[5];
        win_d[5] = tap_up1;
        win_d[6] = win_q[7];
        win_d[7] = win_q[8];
        win_d[8] = s_pixel;
    end

    // Stage p0: window capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q    <= '0;
            vld_p0_q <= 1'b0;
            sof_p0_q <= 1'b0;
            thr_p0_q <= '0;
        end else if (advance) begin
            vld_p0_q <= accept && (row_eff >= ROW_W'(2)) && (col_eff >= COL_W'(2));
            sof_p0_q <= accept && (row_eff == ROW_W'(2)) && (col_eff == COL_W'(2));
            if (accept) begin
                win_q    <= win_d;
                thr_p0_q <= thr_d;
            end
        end
    end

    // Stage p1: gradients
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_p1_q  <= '0;
            gy_p1_q  <= '0;
            vld_p1_q <= 1'b0;
            sof_p1_q <= 1'b0;
            thr_p1_q <= '0;
        end else if (advance) begin
            gx_p1_q  <= grad(side_sum(win_q[2], win_q[5], win_q[8]),
                             side_sum(win_q[0], win_q[3], win_q[6]));
            gy_p1_q  <= grad(side_sum(win_q[6], win_q[7], win_q[8]),
                             side_sum(win_q[0], win_q[1], win_q[2]));
            vld_p1_q <= vld_p0_q;
            sof_p1_q <= sof_p0_q;
            thr_p1_q <= thr_p0_q;
        end
    end

    // Stage p2: magnitude and threshold compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_p2_q  <= '0;
            edge_p2_q <= 1'b0;
            vld_p2_q  <= 1'b0;
            sof_p2_q  <= 1'b0;
        end else if (advance) begin
            mag_p2_q  <= abs_g(gx_p1_q) + abs_g(gy_p1_q);
            edge_p2_q <= (abs_g(gx_p1_q) + abs_g(gy_p1_q)) > thr_p1_q;
            vld_p2_q  <= vld_p1_q;
            sof_p2_q  <= sof_p1_q;
        end
    end

    assign m_valid = vld_p2_q;
    assign m_sof   = sof_p2_q;
    assign m_mag   = mag_p2_q;
    assign m_edge  = edge_p2_q;

endmodule

// File: tb/tb_sobel_stream_detector.sv
// Scoreboard bench for sobel_stream_detector: a 4x4 and a 3x3 instance driven
// with directed frames; a monitor pops expected results on every handshake.
module tb_sobel_stream_detector;

    typedef struct {
        int mag;
        int edg;
        int sof;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [10:0] cfg_threshold4, cfg_threshold3;
    logic        s_valid4, s_ready4, s_sof4, m_valid4, m_ready4, m_sof4, m_edge4;
    logic [7:0]  s_pixel4;
    logic [10:0] m_mag4;
    logic        s_valid3, s_ready3, s_sof3, m_valid3, m_ready3, m_sof3, m_edge3;
    logic [7:0]  s_pixel3;
    logic [10:0] m_mag3;

    exp_t q4[$];
    exp_t q3[$];
    exp_t e4, e3;
    int   checks;
    int   errors;

    sobel_stream_detector #(.PIXEL_W(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk           (clk),
        .rst           (rst),
        .cfg_threshold (cfg_threshold4),
        .s_valid       (s_valid4),
        .s_ready       (s_ready4),
        .s_sof         (s_sof4),
        .s_pixel       (s_pixel4),
        .m_valid       (m_valid4),
        .m_ready       (m_ready4),
        .m_sof         (m_sof4),
        .m_mag         (m_mag4),
        .m_edge        (m_edge4)
    );

    sobel_stream_detector #(.PIXEL_W(8), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .cfg_threshold (cfg_threshold3),
        .s_valid       (s_valid3),
        .s_ready       (s_ready3),
        .s_sof         (s_sof3),
        .s_pixel       (s_pixel3),
        .m_valid       (m_valid3),
        .m_ready       (m_ready3),
        .m_sof         (m_sof3),
        .m_mag         (m_mag3),
        .m_edge        (m_edge3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push4(input int mag, input int edg, input int sof);
        q4.push_back('{mag, edg, sof});
    endtask

    task automatic push3(input int mag, input int edg, input int sof);
        q3.push_back('{mag, edg, sof});
    endtask

    task automatic push_vertical_edge();
        push4(1020, 1, 1);
        push4(0,    0, 0);
        push4(1020, 1, 0);
        push4(0,    0, 0);
    endtask

    task automatic send4(input logic [7:0] px, input logic sof);
        int g;
        g = 0;
        s_valid4 = 1'b1;
        s_pixel4 = px;
        s_sof4   = sof;
        @(negedge clk);
        while (!s_ready4 && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (!s_ready4) chk("send4_timeout", int'(s_ready4), 1);
        @(posedge clk);
        #1;
        s_valid4 = 1'b0;
        s_sof4   = 1'b0;
    endtask

    task automatic send3(input logic [7:0] px, input logic sof);
        int g;
        g = 0;
        s_valid3 = 1'b1;
        s_pixel3 = px;
        s_sof3   = sof;
        @(negedge clk);
        while (!s_ready3 && g < 200) begin
            g++;
            @(negedge clk);
        end
        if (!s_ready3) chk("send3_timeout", int'(s_ready3), 1);
        @(posedge clk);
        #1;
        s_valid3 = 1'b0;
        s_sof3   = 1'b0;
    endtask

    // Sends npix pixels whose value depends only on the column; first carries sof.
    task automatic send_cols4(input int npix, input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
        logic [7:0] pat [4];
        pat = '{c0, c1, c2, c3};
        for (int n = 0; n < npix; n++) begin
            send4(pat[n % 4], n == 0);
        end
    endtask

    task automatic send_rows3(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        logic [7:0] pat [3];
        pat = '{r0, r1, r2};
        for (int n = 0; n < 9; n++) begin
            send3(pat[n / 3], n == 0);
        end
    endtask

    task automatic wait_valid4(input string name);
        int g;
        g = 0;
        @(negedge clk);
        while (!m_valid4 && g < 50) begin
            g++;
            @(negedge clk);
        end
        chk(name, int'(m_valid4), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cfg_threshold4 = '0;
        cfg_threshold3 = '0;
        s_valid4 = 1'b0; s_sof4 = 1'b0; s_pixel4 = '0; m_ready4 = 1'b1;
        s_valid3 = 1'b0; s_sof3 = 1'b0; s_pixel3 = '0; m_ready3 = 1'b1;

        @(negedge clk);
        chk("reset_s_ready", int'(s_ready4), 0);
        chk("reset_m_valid", int'(m_valid4), 0);
        chk("reset_m_sof",   int'(m_sof4),   0);
        chk("reset_m_mag",   int'(m_mag4),   0);
        chk("reset_m_edge",  int'(m_edge4),  0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("release_s_ready4", int'(s_ready4), 1);
        chk("release_s_ready3", int'(s_ready3), 1);

        fork
            forever begin
                @(negedge clk);
                if (m_valid4 && m_ready4) begin
                    if (q4.size() == 0) begin
                        chk("extra_result4", int'(m_valid4), 0);
                    end else begin
                        e4 = q4.pop_front();
                        chk("mag4",  int'(m_mag4),  e4.mag);
                        chk("edge4", int'(m_edge4), e4.edg);
                        chk("sof4",  int'(m_sof4),  e4.sof);
                    end
                end
                if (m_valid3 && m_ready3) begin
                    if (q3.size() == 0) begin
                        chk("extra_result3", int'(m_valid3), 0);
                    end else begin
                        e3 = q3.pop_front();
                        chk("mag3",  int'(m_mag3),  e3.mag);
                        chk("edge3", int'(m_edge3), e3.edg);
                        chk("sof3",  int'(m_sof3),  e3.sof);
                    end
                end
            end
        join_none

        // All-zero frame
        cfg_threshold4 = 11'd400;
        push4(0, 0, 1); push4(0, 0, 0); push4(0, 0, 0); push4(0, 0, 0);
        send_cols4(16, 8'd0, 8'd0, 8'd0, 8'd0);

        // Vertical edge frame
        push_vertical_edge();
        send_cols4(16, 8'd0, 8'd255, 8'd255, 8'd255);

        // 3x3 horizontal gradient, two frames with different thresholds
        push3(404, 1, 1);
        push3(404, 0, 1);
        cfg_threshold3 = 11'd400;
        send3(8'd201, 1'b1);
        cfg_threshold3 = 11'd0;
        for (int n = 1; n < 9; n++) send3(n < 3 ? 8'd201 : (n < 6 ? 8'd150 : 8'd100), 1'b0);
        cfg_threshold3 = 11'd404;
        send_rows3(8'd201, 8'd150, 8'd100);

        // Backpressure on the vertical edge frame
        repeat (6) @(posedge clk);
        #1;
        m_ready4 = 1'b0;
        push_vertical_edge();
        fork
            send_cols4(16, 8'd0, 8'd255, 8'd255, 8'd255);
            begin
                wait_valid4("stall_wait_valid");
                for (int i = 0; i < 5; i++) begin
                    chk("stall_s_ready", int'(s_ready4), 0);
                    chk("stall_m_valid", int'(m_valid4), 1);
                    chk("stall_m_mag",   int'(m_mag4),   1020);
                    chk("stall_m_edge",  int'(m_edge4),  1);
                    chk("stall_m_sof",   int'(m_sof4),   1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 m_ready4 = 1'b1;
            end
        join

        // Partial frame abandoned by a new sof
        repeat (6) @(posedge clk);
        #1;
        send_cols4(5, 8'd10, 8'd20, 8'd30, 8'd40);
        push4(0, 0, 1); push4(0, 0, 0); push4(0, 0, 0); push4(0, 0, 0);
        send_cols4(16, 8'd88, 8'd88, 8'd88, 8'd88);

        // Asynchronous reset with a result waiting at the output
        repeat (6) @(posedge clk);
        #1;
        m_ready4 = 1'b0;
        send_cols4(12, 8'd0, 8'd255, 8'd255, 8'd255);
        wait_valid4("prereset_wait_valid");
        chk("prereset_m_mag", int'(m_mag4), 1020);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_m_valid", int'(m_valid4), 0);
        chk("async_rst_m_mag",   int'(m_mag4),   0);
        chk("async_rst_m_edge",  int'(m_edge4),  0);
        chk("async_rst_m_sof",   int'(m_sof4),   0);
        chk("async_rst_s_ready", int'(s_ready4), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready4 = 1'b1;
        @(posedge clk);
        #1;
        push_vertical_edge();
        send_cols4(16, 8'd0, 8'd255, 8'd255, 8'd255);

        repeat (20) @(posedge clk);
        #1;
        chk("pending_results4", q4.size(), 0);
        chk("pending_results3", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sobel_stream_detector.md
Name: sobel_stream_detector

Overview:
- Streaming Sobel edge detector that takes one raster-order pixel per accepted beat. This removes the need to present a full 3x3 window every cycle.
- Internally holds two line buffers and a 3x3 window, then computes |Gx|+|Gy|.
- Emits the magnitude and a thresholded edge flag for every interior pixel through a valid/ready output.
- Sits between the camera/frame-reader stream and the edge-map writer. Successor to the fixed 3x3 window detector: parametrised image size and pixel width, run-time threshold, backpressure, frame sync.

Parameters:
- PIXEL_W, 8, input pixel width in bits
- IMG_WIDTH, 640, pixels per line (minimum 3)
- IMG_HEIGHT, 480, lines per frame (minimum 3)
- MAG_W, PIXEL_W+3, width of the magnitude output (fixed derivation, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_threshold  in  MAG_W  edge threshold, sampled on the accepted first pixel of each frame
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept a pixel
- s_sof  in  1  marks the first pixel of a frame; qualified by s_valid&&s_ready
- s_pixel  in  PIXEL_W  unsigned pixel
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts the result
- m_sof  out  1  first interior result of a frame
- m_mag  out  MAG_W  |Gx|+|Gy|
- m_edge  out  1  m_mag > threshold

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: s_ready=0 while rst is high, 1 in the first cycle after release. m_valid=0, m_sof=0, m_mag=0, m_edge=0. Column/row counters=0. Latched threshold=0. Window registers=0. Line-buffer contents are don't-care.
- Accept: a beat occurs when s_valid&&s_ready. The counters (col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1) advance only on accepted beats.
  - col wraps to 0 and row increments.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0.
- s_sof: when accepted with s_sof=1, the beat is forced to (0,0) regardless of the counters. Any partial frame is discarded; no results are flushed for it. cfg_threshold is latched on this beat.
  - Without s_sof, the first pixel after reset is treated as (0,0).
- Window: the accepted pixel shifts into the window right column together with the two line-buffer taps. The line buffers are written at index col.
- A window is valid when the accepted pixel has row>=2 and col>=2. The centre is then (row-1, col-1).
- Result count: exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) results per frame, in raster order. No border outputs.
- Arithmetic: taps p1..p9 are row-major with p1 top-left.
  - Gx=(p3+2p6+p9)-(p1+2p4+p7)
  - Gy=(p7+2p8+p9)-(p1+2p2+p3)
  - Gx and Gy are signed PIXEL_W+3 bits. Each |G| fits in PIXEL_W+2 bits; the sum fits MAG_W with no saturation.
- Edge compare: strict greater-than against the latched threshold.
- Pipeline: 3 stages (window capture -> Gx/Gy -> abs/sum/compare). Latency from the accepting beat to m_valid is 3 cycles when unstalled. Throughput is 1 result per cycle.
- Backpressure: the whole pipeline advances only when !(m_valid && !m_ready).
  - s_ready = !rst_q && !(m_valid && !m_ready).
  - m_mag, m_edge and m_sof stay stable while m_valid=1 and m_ready=0.
  - No result is dropped or duplicated.
- m_sof: 1 on the result whose centre is (1,1).
- Reset mid-frame: all in-flight results are discarded. The next frame needs s_sof or starts at (0,0).

Decomposition:
- Shared package sobel_pkg holds:
  - the MAG_W derivation function
  - the kernel coefficient constants
  - a window typedef (9 x PIXEL_W)
- One sub-module: sobel_line_buffer, a single-port read-before-write RAM of IMG_WIDTH x PIXEL_W. It is instantiated twice, or once as 2*PIXEL_W wide.

Test Plan:
- IMG 4x4, all pixels 0, threshold 400 -> 4 results, all m_mag=0, m_edge=0; m_sof only on the first.
- IMG 4x4, each row 0,255,255,255, threshold 400 -> results in order mag 1020,0,1020,0; edge 1,0,1,0.
- IMG 3x3, rows 201/150/100 -> single result mag 404. Threshold 400 gives edge=1; threshold 404 (next frame) gives edge=0.
- IMG 4x4, vertical-edge frame with m_ready held low 5 cycles while m_valid=1 -> s_ready=0, output stable, all 4 results delivered exactly once.
- Accept 5 pixels of a frame, then s_sof with a new constant-88 frame -> only the new frame's 4 results (mag 0) appear; no stale results.
- Assert rst for 2 cycles mid-frame -> all outputs 0 immediately (asynchronous). The next full frame reproduces the scenario-2 results.
